hpdcache_sram_1rw_ctrl: RTL and testbench

HPDCACHE_SRAM_1RW_CTRL -- requirements
Module: hpdcache_sram_1rw_ctrl

---
 rtl/hpdcache_sram_1rw_ctrl_pkg.sv | 17 +
 rtl/hpdcache_rr_arb2.sv | 17 +
 rtl/hpdcache_sram_1rw_ctrl.sv | 151 +++++++++++++++
 tb/tb_hpdcache_sram_1rw_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_sram_1rw_ctrl_pkg.sv
// rtl/hpdcache_sram_1rw_ctrl_pkg.sv - shared types and constants for the 1RW SRAM controller
package hpdcache_sram_1rw_ctrl_pkg;

  typedef enum logic {
    SRAM_ST_INIT = 1'b0,
    SRAM_ST_RUN  = 1'b1
  } sram_ctrl_state_e;

  // Priority flag encoding: which requester wins the next conflict
  localparam logic PRIO_WR = 1'b0;
  localparam logic PRIO_RD = 1'b1;

  // Requester slots on the two-way arbiter
  localparam int unsigned ARB_WR = 0;
  localparam int unsigned ARB_RD = 1;

endpackage

// File: rtl/hpdcache_rr_arb2.sv
// rtl/hpdcache_rr_arb2.sv - two-way round-robin arbiter, priority flag kept by the caller
module hpdcache_rr_arb2
  import hpdcache_sram_1rw_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (prio == PRIO_WR) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/hpdcache_sram_1rw_ctrl.sv
// rtl/hpdcache_sram_1rw_ctrl.sv - single-port SRAM front end: zeroing sweep, read/write arbitration, response hold
module hpdcache_sram_1rw_ctrl
  import hpdcache_sram_1rw_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 6,
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned NDATA     = 1,
  parameter int unsigned DEPTH     = 2**ADDR_SIZE
)(
  input  logic                            clk,
  input  logic                            rst,

  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [ADDR_SIZE-1:0]            wr_addr,
  input  logic [NDATA*DATA_SIZE-1:0]      wr_data,
  input  logic [NDATA*DATA_SIZE/8-1:0]    wr_be,

  input  logic                            rd_valid,
  output logic                            rd_ready,
  input  logic [ADDR_SIZE-1:0]            rd_addr,

  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [NDATA*DATA_SIZE-1:0]      rsp_data,

  output logic                            sram_cs,
  output logic                            sram_we,
  output logic [ADDR_SIZE-1:0]            sram_addr,
  output logic [NDATA*DATA_SIZE-1:0]      sram_wdata,
  output logic [NDATA*DATA_SIZE/8-1:0]    sram_wbyteenable,
  input  logic [NDATA*DATA_SIZE-1:0]      sram_rdata,

  output logic                            init_done
);

  localparam int unsigned          WORD_W    = NDATA*DATA_SIZE;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  sram_ctrl_state_e       r_state;
  sram_ctrl_state_e       w_state_nxt;
  logic [ADDR_SIZE-1:0]   r_init_cnt;
  logic [ADDR_SIZE-1:0]   w_init_cnt_nxt;
  logic                   r_prio;
  logic                   r_rsp_pend;
  logic                   r_rsp_first;
  logic [WORD_W-1:0]      r_rsp_hold;

  logic                   w_run;
  logic                   w_rsp_acc;
  logic                   w_rd_elig;
  logic                   w_rd_req;
  logic [1:0]             w_arb_req;
  logic [1:0]             w_gnt;
  logic                   w_conflict;

  assign w_run     = (r_state == SRAM_ST_RUN);
  assign w_rsp_acc = r_rsp_pend & rsp_ready;
  // A read may only issue if its response slot is free by the time the data comes back
  assign w_rd_elig = ~r_rsp_pend | w_rsp_acc;
  assign w_rd_req  = rd_valid & w_rd_elig;

  assign w_arb_req  = w_run ? {w_rd_req, wr_valid} : 2'b00;
  assign w_conflict = w_run & wr_valid & w_rd_req;

  hpdcache_rr_arb2 u_arb (
    .req  (w_arb_req),
    .prio (r_prio),
    .gnt  (w_gnt)
  );

  // Readies mirror the arbiter decision without looking at the requester's own valid
  assign wr_ready = w_run & ~(w_rd_req & (r_prio == PRIO_RD));
  assign rd_ready = w_run & w_rd_elig & ~(wr_valid & (r_prio == PRIO_WR));

  assign init_done = w_run;
  assign rsp_valid = r_rsp_pend;
  assign rsp_data  = r_rsp_first ? sram_rdata : r_rsp_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= SRAM_ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_init_cnt_nxt   = r_init_cnt;
    sram_cs          = 1'b0;
    sram_we          = 1'b0;
    sram_addr        = wr_addr;
    sram_wdata       = wr_data;
    sram_wbyteenable = wr_be;
    unique case (r_state)
      SRAM_ST_INIT: begin
        sram_cs          = 1'b1;
        sram_we          = 1'b1;
        sram_addr        = r_init_cnt;
        sram_wdata       = '0;
        sram_wbyteenable = '1;
        if (r_init_cnt == LAST_ADDR) begin
          w_state_nxt = SRAM_ST_RUN;
        end else begin
          w_init_cnt_nxt = r_init_cnt + ADDR_SIZE'(1);
        end
      end
      SRAM_ST_RUN: begin
        if (w_gnt[ARB_WR]) begin
          sram_cs = 1'b1;
          sram_we = 1'b1;
        end else if (w_gnt[ARB_RD]) begin
          sram_cs   = 1'b1;
          sram_addr = rd_addr;
        end
      end
      default: begin
        w_state_nxt = SRAM_ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio      <= PRIO_WR;
      r_rsp_pend  <= 1'b0;
      r_rsp_first <= 1'b0;
    end else begin
      if (w_conflict) begin
        r_prio <= ~r_prio;
      end
      r_rsp_first <= w_gnt[ARB_RD];
      if (w_gnt[ARB_RD]) begin
        r_rsp_pend <= 1'b1;
      end else if (w_rsp_acc) begin
        r_rsp_pend <= 1'b0;
      end
    end
  end

  // The SRAM output is only trustworthy for one cycle; later writes may disturb it
  always_ff @(posedge clk) begin
    if (r_rsp_first) begin
      r_rsp_hold <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_hpdcache_sram_1rw_ctrl.sv
// tb/tb_hpdcache_sram_1rw_ctrl.sv - directed bench for the 1RW SRAM controller
module tb_hpdcache_sram_1rw_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_valid, wr_ready;
  logic [2:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        rd_valid, rd_ready;
  logic [2:0]  rd_addr;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic        sram_cs, sram_we;
  logic [2:0]  sram_addr;
  logic [63:0] sram_wdata;
  logic [7:0]  sram_wbyteenable;
  logic [63:0] sram_rdata;
  logic        init_done;

  int n_checks = 0;
  int n_fail   = 0;

  hpdcache_sram_1rw_ctrl #(
    .ADDR_SIZE (3),
    .DATA_SIZE (64),
    .NDATA     (1),
    .DEPTH     (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_be            (wr_be),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_addr          (rd_addr),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .sram_cs          (sram_cs),
    .sram_we          (sram_we),
    .sram_addr        (sram_addr),
    .sram_wdata       (sram_wdata),
    .sram_wbyteenable (sram_wbyteenable),
    .sram_rdata       (sram_rdata),
    .init_done        (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: garbage at power-up, read data valid next cycle, disturbed by writes
  logic [63:0] mem [8] = '{default: 64'hDEADBEEFDEADBEEF};
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 8; b++)
          if (sram_wbyteenable[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        sram_rdata <= 64'hBADBADBADBADBAD0;
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic        wv;
    logic [2:0]  wa;
    logic [63:0] wd;
    logic [7:0]  wb;
    logic        rv;
    logic [2:0]  ra;
    logic        rr;
    logic        e_wrdy;
    logic        e_rrdy;
    logic        e_cs;
    logic        e_we;
    logic [2:0]  e_addr;
    logic        e_rsv;
    logic [63:0] e_rsd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wv, input logic [2:0] wa, input logic [63:0] wd,
                              input logic [7:0] wb, input logic rv, input logic [2:0] ra,
                              input logic rr, input logic ewr, input logic erd, input logic ecs,
                              input logic ewe, input logic [2:0] ea, input logic ersv,
                              input logic [63:0] ersd);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.wb = wb; v.rv = rv; v.ra = ra; v.rr = rr;
    v.e_wrdy = ewr; v.e_rrdy = erd; v.e_cs = ecs; v.e_we = ewe; v.e_addr = ea;
    v.e_rsv = ersv; v.e_rsd = ersd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [2:0] wa, input logic [63:0] wd,
                       input logic [7:0] wb, input logic rv, input logic [2:0] ra, input logic rr);
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = wb;
    rd_valid = rv; rd_addr = ra; rsp_ready = rr;
  endtask

  // Requests are held high during the sweep to show they are ignored
  task automatic run_sweep(input int abort_at);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 3'd7, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 3'd6, 1'b1);
      #1;
      chk($sformatf("sweep%0d_addr", i), 64'(sram_addr), 64'(i));
      chk($sformatf("sweep%0d_cs", i), 64'(sram_cs), 64'd1);
      chk($sformatf("sweep%0d_we", i), 64'(sram_we), 64'd1);
      chk($sformatf("sweep%0d_wdata", i), sram_wdata, 64'd0);
      chk($sformatf("sweep%0d_be", i), 64'(sram_wbyteenable), 64'hFF);
      chk($sformatf("sweep%0d_init_done", i), 64'(init_done), 64'd0);
      chk($sformatf("sweep%0d_wr_ready", i), 64'(wr_ready), 64'd0);
      chk($sformatf("sweep%0d_rd_ready", i), 64'(rd_ready), 64'd0);
      chk($sformatf("sweep%0d_rsp_valid", i), 64'(rsp_valid), 64'd0);
      if (i == abort_at) begin
        rst = 1'b1;
        break;
      end
    end
    if (abort_at < 0) begin
      @(negedge clk);
      drive(1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 3'd0, 1'b1);
      #1;
      chk("sweep_done_init_done", 64'(init_done), 64'd1);
      chk("sweep_done_cs", 64'(sram_cs), 64'd0);
    end
  endtask

  localparam logic [63:0] WD3 = 64'h0123456789ABCDEF;
  localparam logic [63:0] P2  = 64'h5555000055550000;

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 3'd0, 1'b0);

    // merge, alternation, held response while writes hit the same row
    tbl.push_back(mk(1'b1, 3'd3, 64'h1122334455667788, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 64'd0));
    tbl.push_back(mk(1'b1, 3'd3, 64'hAAAAAAAAAAAAAAAA, 8'h01, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 64'd0));
    tbl.push_back(mk(1'b0, 3'd0, 64'd0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 64'd0));
    tbl.push_back(mk(1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 64'h11223344556677AA));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(1'b1, 3'd0, WD3, 8'hFF, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, (k != 0), 64'd0));
      tbl.push_back(mk(1'b1, 3'd0, WD3, 8'hFF, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 64'd0));
    end
    tbl.push_back(mk(1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 64'd0));
    tbl.push_back(mk(1'b1, 3'd2, P2, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 64'd0));
    tbl.push_back(mk(1'b0, 3'd0, 64'd0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 64'd0));
    tbl.push_back(mk(1'b1, 3'd2, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, P2));
    tbl.push_back(mk(1'b1, 3'd2, 64'h0102030405060708, 8'h0F, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, P2));
    tbl.push_back(mk(1'b1, 3'd2, 64'h1111111111111111, 8'h80, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, P2));
    tbl.push_back(mk(1'b1, 3'd2, 64'h0000000000009900, 8'h02, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, P2));
    tbl.push_back(mk(1'b0, 3'd0, 64'd0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, P2));
    tbl.push_back(mk(1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 64'h11FFFFFF05069908));
    tbl.push_back(mk(1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'd0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_rd_ready", 64'(rd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_sram_addr", 64'(sram_addr), 64'd0);

    run_sweep(-1);

    @(negedge clk);
    drive(1'b0, 3'd0, 64'd0, 8'h00, 1'b1, 3'd5, 1'b1);
    #1;
    chk("rd5_rd_ready", 64'(rd_ready), 64'd1);
    chk("rd5_cs", 64'(sram_cs), 64'd1);
    chk("rd5_we", 64'(sram_we), 64'd0);
    chk("rd5_addr", 64'(sram_addr), 64'd5);
    @(negedge clk);
    drive(1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 3'd0, 1'b1);
    #1;
    chk("rd5_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd5_rsp_data", rsp_data, 64'd0);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drive(tbl[k].wv, tbl[k].wa, tbl[k].wd, tbl[k].wb, tbl[k].rv, tbl[k].ra, tbl[k].rr);
      #1;
      chk($sformatf("v%0d_wr_ready", k), 64'(wr_ready), 64'(tbl[k].e_wrdy));
      chk($sformatf("v%0d_rd_ready", k), 64'(rd_ready), 64'(tbl[k].e_rrdy));
      chk($sformatf("v%0d_cs", k), 64'(sram_cs), 64'(tbl[k].e_cs));
      if (tbl[k].e_cs) begin
        chk($sformatf("v%0d_we", k), 64'(sram_we), 64'(tbl[k].e_we));
        chk($sformatf("v%0d_addr", k), 64'(sram_addr), 64'(tbl[k].e_addr));
        if (tbl[k].e_we) begin
          chk($sformatf("v%0d_wdata", k), sram_wdata, tbl[k].wd);
          chk($sformatf("v%0d_be", k), 64'(sram_wbyteenable), 64'(tbl[k].wb));
        end
      end
      chk($sformatf("v%0d_rsp_valid", k), 64'(rsp_valid), 64'(tbl[k].e_rsv));
      if (tbl[k].e_rsv) chk($sformatf("v%0d_rsp_data", k), rsp_data, tbl[k].e_rsd);
    end

    // flip priority to read, leave a response pending, then reset
    @(negedge clk);
    drive(1'b1, 3'd4, 64'h77, 8'hFF, 1'b1, 3'd5, 1'b1);
    #1;
    chk("pre_conflict_wr_ready", 64'(wr_ready), 64'd1);
    chk("pre_conflict_rd_ready", 64'(rd_ready), 64'd0);
    @(negedge clk);
    drive(1'b0, 3'd0, 64'd0, 8'h00, 1'b1, 3'd5, 1'b0);
    #1;
    chk("pend_rd_ready", 64'(rd_ready), 64'd1);
    @(negedge clk);
    drive(1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 3'd0, 1'b0);
    #1;
    chk("pend_rsp_valid", 64'(rsp_valid), 64'd1);
    rst = 1'b1;

    run_sweep(4);
    run_sweep(-1);

    @(negedge clk);
    drive(1'b1, 3'd4, 64'h99, 8'hFF, 1'b1, 3'd3, 1'b1);
    #1;
    chk("post_rst_prio_wr_ready", 64'(wr_ready), 64'd1);
    chk("post_rst_prio_rd_ready", 64'(rd_ready), 64'd0);
    @(negedge clk);
    drive(1'b0, 3'd0, 64'd0, 8'h00, 1'b1, 3'd3, 1'b1);
    #1;
    chk("post_rst_rd_ready", 64'(rd_ready), 64'd1);
    @(negedge clk);
    drive(1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 3'd0, 1'b1);
    #1;
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("post_rst_rsp_data", rsp_data, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
